id_stage_hazard: RTL and testbench

Parametrised instruction-decode stage for the MIPS pipeline. It sits between the IF/ID and ID/EX boundaries and holds the register file with write-first bypass, a debug read/write port and the main control decoder. It also detects load-use hazards, resolves BEQ/BNE early in ID, and registers everything into an ID/EX pipeline register with stall, flush and debug-freeze.

---
 rtl/id_stage_hazard.sv | 214 +++++++++++++++++++++
 tb/tb_id_stage_hazard.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hazard.sv
// MIPS instruction-decode stage: register file with write-first bypass and debug port,
// control decode, load-use stall, early BEQ/BNE resolution and the ID/EX pipeline register.
module id_stage_hazard #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic               i_wb_write,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_mem_read,
  input  logic [NB_REG-1:0]  i_ex_rt,
  input  logic               i_flush,
  input  logic               i_debug_mode,
  input  logic               i_debug_write,
  input  logic [NB_REG-1:0]  i_debug_addr,
  input  logic [NB_DATA-1:0] i_debug_data,
  output logic               o_stall,
  output logic               o_branch_taken,
  output logic [NB_ADDR-1:0] o_branch_target,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_valid,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_data_1,
  output logic [NB_DATA-1:0] o_data_2,
  output logic [NB_DATA-1:0] o_sign_extend,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [5:0]         o_funct,
  output logic               o_reg_dst,
  output logic               o_alu_src,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_reg_write,
  output logic               o_mem_to_reg
);

  localparam int NUM_REGS = 2 ** NB_REG;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  logic [NB_DATA-1:0] regs [NUM_REGS];

  logic [5:0]         opcode;
  logic [NB_REG-1:0]  rs;
  logic [NB_REG-1:0]  rt;
  logic [NB_REG-1:0]  rd;
  logic [5:0]         funct;
  logic [15:0]        imm;
  logic [NB_DATA-1:0] sign_ext;
  logic [NB_ADDR-1:0] branch_offset;

  logic               wb_en;
  logic               dbg_en;
  logic [NB_DATA-1:0] data_1;
  logic [NB_DATA-1:0] data_2;
  logic               operands_eq;

  logic dec_reg_dst;
  logic dec_alu_src;
  logic dec_mem_read;
  logic dec_mem_write;
  logic dec_reg_write;
  logic dec_mem_to_reg;
  logic reads_rt;
  logic is_beq;
  logic is_bne;
  logic bubble;

  assign opcode        = i_instruction[31:26];
  assign rs            = NB_REG'(i_instruction[25:21]);
  assign rt            = NB_REG'(i_instruction[20:16]);
  assign rd            = NB_REG'(i_instruction[15:11]);
  assign funct         = i_instruction[5:0];
  assign imm           = i_instruction[15:0];
  assign sign_ext      = {{(NB_DATA - 16){imm[15]}}, imm};
  assign branch_offset = {{(NB_ADDR - 18){imm[15]}}, imm, 2'b00};

  // Debug mode owns the single write port; WB writes in that window are lost.
  assign wb_en  = !i_debug_mode && i_wb_write && (i_wb_addr != '0);
  assign dbg_en = i_debug_mode && i_debug_write && (i_debug_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (dbg_en) begin
      regs[i_debug_addr] <= i_debug_data;
    end else if (wb_en) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Write-first read: a same-cycle WB write to the source register is forwarded.
  always_comb begin
    data_1 = '0;
    data_2 = '0;
    if (rs != '0) begin
      data_1 = (wb_en && (i_wb_addr == rs)) ? i_wb_data : regs[rs];
    end
    if (rt != '0) begin
      data_2 = (wb_en && (i_wb_addr == rt)) ? i_wb_data : regs[rt];
    end
  end

  assign o_debug_data = (i_debug_addr == '0) ? '0 : regs[i_debug_addr];

  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    reads_rt       = 1'b0;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        reads_rt      = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        reads_rt      = 1'b1;
      end
      OP_BEQ: begin
        is_beq   = 1'b1;
        reads_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne   = 1'b1;
        reads_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // rt only counts as a hazard source when the instruction actually reads it.
  assign o_stall = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                   ((i_ex_rt == rs) || ((i_ex_rt == rt) && reads_rt));

  assign operands_eq     = (data_1 == data_2);
  assign o_branch_taken  = i_valid && !o_stall && !i_flush && !i_debug_mode &&
                           ((is_beq && operands_eq) || (is_bne && !operands_eq));
  assign o_branch_target = i_pc + branch_offset;

  assign bubble = i_flush || o_stall || !i_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset || (!i_debug_mode && bubble)) begin
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_instruction <= '0;
      o_data_1      <= '0;
      o_data_2      <= '0;
      o_sign_extend <= '0;
      o_rs          <= '0;
      o_rt          <= '0;
      o_rd          <= '0;
      o_funct       <= '0;
      o_reg_dst     <= 1'b0;
      o_alu_src     <= 1'b0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_reg_write   <= 1'b0;
      o_mem_to_reg  <= 1'b0;
    end else if (!i_debug_mode) begin
      o_valid       <= 1'b1;
      o_pc          <= i_pc;
      o_instruction <= i_instruction;
      o_data_1      <= data_1;
      o_data_2      <= data_2;
      o_sign_extend <= sign_ext;
      o_rs          <= rs;
      o_rt          <= rt;
      o_rd          <= rd;
      o_funct       <= funct;
      o_reg_dst     <= dec_reg_dst;
      o_alu_src     <= dec_alu_src;
      o_mem_read    <= dec_mem_read;
      o_mem_write   <= dec_mem_write;
      o_reg_write   <= dec_reg_write;
      o_mem_to_reg  <= dec_mem_to_reg;
    end
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard: combinational outputs checked mid-cycle,
// ID/EX payload checked against an expected queue after each rising edge.
module tb_id_stage_hazard;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 32;
  localparam int NB_INST = 32;
  localparam int NB_REG  = 5;
  localparam int W = 1 + NB_ADDR + NB_INST + 3 * NB_DATA + 3 * NB_REG + 6 + 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               valid;
  logic [NB_ADDR-1:0] pc;
  logic [NB_INST-1:0] instruction;
  logic               wb_write;
  logic [NB_REG-1:0]  wb_addr;
  logic [NB_DATA-1:0] wb_data;
  logic               ex_mem_read;
  logic [NB_REG-1:0]  ex_rt;
  logic               flush;
  logic               debug_mode;
  logic               debug_write;
  logic [NB_REG-1:0]  debug_addr;
  logic [NB_DATA-1:0] debug_data_in;

  logic               stall;
  logic               branch_taken;
  logic [NB_ADDR-1:0] branch_target;
  logic [NB_DATA-1:0] debug_data_out;
  logic               q_valid;
  logic [NB_ADDR-1:0] q_pc;
  logic [NB_INST-1:0] q_instruction;
  logic [NB_DATA-1:0] q_data_1;
  logic [NB_DATA-1:0] q_data_2;
  logic [NB_DATA-1:0] q_sign_extend;
  logic [NB_REG-1:0]  q_rs;
  logic [NB_REG-1:0]  q_rt;
  logic [NB_REG-1:0]  q_rd;
  logic [5:0]         q_funct;
  logic               q_reg_dst;
  logic               q_alu_src;
  logic               q_mem_read;
  logic               q_mem_write;
  logic               q_reg_write;
  logic               q_mem_to_reg;

  id_stage_hazard #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_INST(NB_INST), .NB_REG(NB_REG)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_pc(pc), .i_instruction(instruction),
    .i_wb_write(wb_write), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_flush(flush),
    .i_debug_mode(debug_mode), .i_debug_write(debug_write),
    .i_debug_addr(debug_addr), .i_debug_data(debug_data_in),
    .o_stall(stall), .o_branch_taken(branch_taken), .o_branch_target(branch_target),
    .o_debug_data(debug_data_out),
    .o_valid(q_valid), .o_pc(q_pc), .o_instruction(q_instruction),
    .o_data_1(q_data_1), .o_data_2(q_data_2), .o_sign_extend(q_sign_extend),
    .o_rs(q_rs), .o_rt(q_rt), .o_rd(q_rd), .o_funct(q_funct),
    .o_reg_dst(q_reg_dst), .o_alu_src(q_alu_src), .o_mem_read(q_mem_read),
    .o_mem_write(q_mem_write), .o_reg_write(q_reg_write), .o_mem_to_reg(q_mem_to_reg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  logic [W-1:0] obs;
  assign obs = {q_valid, q_pc, q_instruction, q_data_1, q_data_2, q_sign_extend,
                q_rs, q_rt, q_rd, q_funct,
                q_reg_dst, q_alu_src, q_mem_read, q_mem_write, q_reg_write, q_mem_to_reg};

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] last_exp;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected ID/EX contents for an accepted instruction, decoded from the opcode table.
  function automatic logic [W-1:0] exp_load(input logic [31:0] epc, input logic [31:0] inst,
                                             input logic [31:0] d1, input logic [31:0] d2);
    logic [5:0]  op;
    logic [31:0] se;
    logic        rdst, alu, mr, mw, rw, m2r;
    op   = inst[31:26];
    se   = {{16{inst[15]}}, inst[15:0]};
    rdst = (op == 6'h00);
    alu  = (op == 6'h08) || (op == 6'h23) || (op == 6'h2B);
    mr   = (op == 6'h23);
    mw   = (op == 6'h2B);
    rw   = (op == 6'h00) || (op == 6'h08) || (op == 6'h23);
    m2r  = (op == 6'h23);
    return {1'b1, epc, inst, d1, d2, se, inst[25:21], inst[20:16], inst[15:11], inst[5:0],
            rdst, alu, mr, mw, rw, m2r};
  endfunction

  task automatic push(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    last_exp = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Driver tasks
  task automatic idle();
    valid         = 1'b0;
    pc            = '0;
    instruction   = '0;
    wb_write      = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    ex_mem_read   = 1'b0;
    ex_rt         = '0;
    flush         = 1'b0;
    debug_mode    = 1'b0;
    debug_write   = 1'b0;
    debug_addr    = '0;
    debug_data_in = '0;
  endtask

  task automatic drive_inst(input logic [31:0] p, input logic [31:0] inst);
    valid       = 1'b1;
    pc          = p;
    instruction = inst;
  endtask

  localparam logic [31:0] ADD_R1_R2_R3  = 32'h0043_0820;
  localparam logic [31:0] ADDI_R7_R4_M4 = 32'h2087_FFFC;
  localparam logic [31:0] ADD_R1_R0_R4  = 32'h0004_0820;
  localparam logic [31:0] SW_R5_R2      = 32'hAC45_0000;
  localparam logic [31:0] ADDI_R5_R2_1  = 32'h2045_0001;
  localparam logic [31:0] BEQ_R2_R2_M1  = 32'h1042_FFFF;
  localparam logic [31:0] BNE_R2_R2_M1  = 32'h1442_FFFF;
  localparam logic [31:0] ADD_R1_R6_R2  = 32'h00C2_0820;

  initial begin
    idle();
    reset = 1'b1;
    last_exp = '0;

    // Reset held for two edges
    @(negedge clk); push("reset_0", '0); tick();
    @(negedge clk); push("reset_1", '0); tick();
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 32; a += 5) begin
      debug_addr = NB_REG'(a);
      #1;
      check("reset_dbg_read", W'(debug_data_out), W'(0));
    end
    idle();
    push("idle_bubble", '0); tick();

    // Debug writes r2=2, r3=3, r0=ffff; ID/EX frozen meanwhile
    @(negedge clk);
    debug_mode = 1'b1; debug_write = 1'b1; debug_addr = 5'd2; debug_data_in = 32'd2;
    push("dbg_wr_r2_hold", last_exp); tick();
    @(negedge clk);
    debug_addr = 5'd3; debug_data_in = 32'd3;
    push("dbg_wr_r3_hold", last_exp); tick();
    @(negedge clk);
    debug_addr = 5'd0; debug_data_in = 32'hFFFF;
    push("dbg_wr_r0_hold", last_exp); tick();
    @(negedge clk);
    debug_write = 1'b0;
    debug_addr = 5'd0; #1; check("dbg_r0_ignored", W'(debug_data_out), W'(0));
    debug_addr = 5'd2; #1; check("dbg_rd_r2", W'(debug_data_out), W'(2));
    debug_addr = 5'd3; #1; check("dbg_rd_r3", W'(debug_data_out), W'(3));
    idle();

    // ADD r1, r2, r3
    drive_inst(32'h104, ADD_R1_R2_R3);
    #1;
    check("add_no_stall", W'(stall), W'(0));
    check("add_no_branch", W'(branch_taken), W'(0));
    push("add_idex", exp_load(32'h104, ADD_R1_R2_R3, 32'd2, 32'd3)); tick();

    // WB r4=DEAD bypassed into ADDI r7, r4, -4; debug port not bypassed
    @(negedge clk);
    idle();
    drive_inst(32'h200, ADDI_R7_R4_M4);
    wb_write = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEAD; debug_addr = 5'd4;
    #1;
    check("dbg_no_bypass", W'(debug_data_out), W'(0));
    check("br_target_neg", W'(branch_target), W'(32'h1F0));
    push("addi_bypass", exp_load(32'h200, ADDI_R7_R4_M4, 32'hDEAD, 32'd0)); tick();

    // WB to r0 dropped; r4 now from the array
    @(negedge clk);
    idle();
    drive_inst(32'h204, ADD_R1_R0_R4);
    wb_write = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; debug_addr = 5'd4;
    #1;
    check("dbg_rd_r4", W'(debug_data_out), W'(32'hDEAD));
    push("add_r0_bypass", exp_load(32'h204, ADD_R1_R0_R4, 32'd0, 32'hDEAD)); tick();
    @(negedge clk);
    idle();
    #1;
    check("r0_still_zero", W'(debug_data_out), W'(0));
    push("idle_bubble_2", '0); tick();

    // Load-use on rt of SW -> one-cycle stall and bubble, then accepted
    @(negedge clk);
    drive_inst(32'h300, SW_R5_R2);
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    check("sw_stall", W'(stall), W'(1));
    push("sw_stall_bubble", '0); tick();
    @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    check("sw_stall_released", W'(stall), W'(0));
    push("sw_idex", exp_load(32'h300, SW_R5_R2, 32'd2, 32'd0)); tick();

    // ADDI writes rt, so a load to rt is not a hazard; a load to rs is
    @(negedge clk);
    drive_inst(32'h304, ADDI_R5_R2_1);
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    check("addi_rt_no_stall", W'(stall), W'(0));
    push("addi_idex", exp_load(32'h304, ADDI_R5_R2_1, 32'd2, 32'd0)); tick();
    @(negedge clk);
    ex_rt = 5'd2;
    #1;
    check("addi_rs_stall", W'(stall), W'(1));
    push("addi_rs_bubble", '0); tick();
    @(negedge clk);
    ex_rt = 5'd0;
    #1;
    check("ex_rt0_no_stall", W'(stall), W'(0));
    push("addi_rs_idex", exp_load(32'h304, ADDI_R5_R2_1, 32'd2, 32'd0)); tick();

    // BEQ r2,r2,-1 at pc 0x10 -> taken to 0x0C
    @(negedge clk);
    idle();
    drive_inst(32'h10, BEQ_R2_R2_M1);
    #1;
    check("beq_taken", W'(branch_taken), W'(1));
    check("beq_target", W'(branch_target), W'(32'h0C));
    push("beq_idex", exp_load(32'h10, BEQ_R2_R2_M1, 32'd2, 32'd2)); tick();

    @(negedge clk);
    drive_inst(32'h10, BNE_R2_R2_M1);
    #1;
    check("bne_not_taken", W'(branch_taken), W'(0));
    check("bne_target", W'(branch_target), W'(32'h0C));
    push("bne_idex", exp_load(32'h10, BNE_R2_R2_M1, 32'd2, 32'd2)); tick();

    @(negedge clk);
    drive_inst(32'h10, BEQ_R2_R2_M1);
    flush = 1'b1;
    #1;
    check("beq_flush_not_taken", W'(branch_taken), W'(0));
    push("beq_flush_bubble", '0); tick();

    // Stall and flush together: bubble, stall still visible
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rt = 5'd2;
    #1;
    check("stall_flush_stall", W'(stall), W'(1));
    check("stall_flush_no_br", W'(branch_taken), W'(0));
    push("stall_flush_bubble", '0); tick();

    // Load something, then freeze with debug mode
    @(negedge clk);
    idle();
    drive_inst(32'h400, ADD_R1_R2_R3);
    push("pre_freeze_idex", exp_load(32'h400, ADD_R1_R2_R3, 32'd2, 32'd3)); tick();
    @(negedge clk);
    drive_inst(32'h10, BEQ_R2_R2_M1);
    debug_mode = 1'b1; wb_write = 1'b1; wb_addr = 5'd6; wb_data = 32'h66; debug_addr = 5'd6;
    #1;
    check("debug_no_branch", W'(branch_taken), W'(0));
    check("debug_rd_r6_old", W'(debug_data_out), W'(0));
    push("freeze_hold_0", last_exp); tick();
    @(negedge clk);
    wb_write = 1'b0;
    #1;
    check("r6_unchanged", W'(debug_data_out), W'(0));
    push("freeze_hold_1", last_exp); tick();

    // Leave debug; r6 read through ID confirms the dropped WB write
    @(negedge clk);
    idle();
    drive_inst(32'h500, ADD_R1_R6_R2);
    push("post_debug_idex", exp_load(32'h500, ADD_R1_R6_R2, 32'd0, 32'd2)); tick();

    // Reset during debug mode clears everything
    @(negedge clk);
    debug_mode = 1'b1;
    reset = 1'b1;
    push("reset_mid_debug", '0); tick();
    @(negedge clk);
    reset = 1'b0;
    debug_addr = 5'd2;
    #1;
    check("reset_clears_r2", W'(debug_data_out), W'(0));
    idle();
    push("final_bubble", '0); tick();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
